// File: rtl/trigger_window_reader.sv
// trigger_window_reader: arms on request, waits for the detector's trigger edge,
// then streams the pre/post-trigger window out of the circular buffer as one
// AXI-Stream packet.
// Optional build macro READER_HEADER_EN: prepends one header beat carrying the
// latched trigger offset.
module trigger_window_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int OFFSET_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [31:0]           trigger_offset,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic [ADDR_WIDTH-1:0] post_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    TRIG_WAIT = 3'd2,
    POST      = 3'd3,
    READ      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [2:0]          DLY_LAST = 3'(OFFSET_DELAY - 1);

  state_t                state;
  logic                  trig_q;
  logic                  trig_edge;
  logic [2:0]            dly;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [ADDR_WIDTH-1:0] post_q;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   len_raw;
  logic [ADDR_WIDTH:0]   len_clamp;
  logic [ADDR_WIDTH-1:0] post_clamp;
  logic                  enter_read;

  logic [DATA_WIDTH:0]   fifo [2];
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  inflight_last;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH:0]   push_word;
  logic [DATA_WIDTH:0]   head;
  logic [2:0]            level;
  logic                  rd_issue;
  logic                  hdr_push;
  logic [DATA_WIDTH:0]   hdr_word;
  logic                  unused_offset_bits;

  assign unused_offset_bits = ^trigger_offset[31:ADDR_WIDTH];

  assign trig_edge  = trigger & ~trig_q;
  assign enter_read = (state == POST) && (post_cnt >= post_q);

  // Window length with post_len clamped so the window never exceeds the buffer
  always_comb begin
    len_raw = {1'b0, pre_len} + {1'b0, post_len} + (ADDR_WIDTH+1)'(1);
    if (len_raw > DEPTH) begin
      post_clamp = '1 - pre_len;
      len_clamp  = DEPTH;
    end else begin
      post_clamp = post_len;
      len_clamp  = len_raw;
    end
  end

  // Previous trigger level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trigger;
  end

`ifdef READER_HEADER_EN
  logic [31:0]            offset_q;
  logic [DATA_WIDTH+31:0] hdr_ext;

  // Trigger offset captured for the header beat alongside the start address
  always_ff @(posedge clk) begin
    if (rst)                                    offset_q <= '0;
    else if (state == TRIG_WAIT && dly == DLY_LAST) offset_q <= trigger_offset;
  end

  assign hdr_ext  = {{DATA_WIDTH{1'b0}}, offset_q};
  assign hdr_push = enter_read;
  assign hdr_word = {1'b0, hdr_ext[DATA_WIDTH-1:0]};
`else
  assign hdr_push = 1'b0;
  assign hdr_word = '0;
`endif

  // Read issue: the projected FIFO level counts the read still in flight, so
  // the read enable is combinational on tready to keep one beat per cycle.
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign level         = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_issue      = (state == READ) && (issued < len_q) && (level < 3'd2);
  assign mem_rd_en     = rd_issue;
  assign mem_rd_addr   = rd_addr;

  assign head          = fifo[rptr];
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_WIDTH];
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  assign push          = inflight | hdr_push;
  assign push_word     = inflight ? {inflight_last, mem_rd_data} : hdr_word;

  // Acquisition sequencing, post-trigger counting and read address generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dly      <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      post_cnt <= '0;
      rd_addr  <= '0;
      len_q    <= '0;
      issued   <= '0;
    end else begin
      case (state)
        IDLE: if (arm) state <= ARMED;
        ARMED: begin
          if (trig_edge) begin
            state    <= TRIG_WAIT;
            dly      <= '0;
            post_cnt <= '0;
            pre_q    <= pre_len;
            post_q   <= post_clamp;
            len_q    <= len_clamp;
          end
        end
        TRIG_WAIT: begin
          if (dly == DLY_LAST) begin
            rd_addr <= trigger_offset[ADDR_WIDTH-1:0] - pre_q;
            state   <= POST;
          end else begin
            dly <= dly + 3'd1;
          end
        end
        POST: begin
          if (enter_read) begin
            issued <= '0;
            state  <= READ;
          end
        end
        READ: if (pop && m_axis_tlast) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if ((state == TRIG_WAIT || state == POST) && wr_valid && post_cnt < post_q)
        post_cnt <= post_cnt + 1'b1;

      if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        issued  <= issued + 1'b1;
      end
    end
  end

  // Two-entry output FIFO fed by the one-cycle read pipeline (or the header)
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo[0]       <= '0;
      fifo[1]       <= '0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      occ           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= ((issued + (ADDR_WIDTH+1)'(1)) == len_q);
      if (push) begin
        fifo[wptr] <= push_word;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_trigger_window_reader.sv
// Bench for trigger_window_reader: directed scenarios plus randomized windows,
// checked against a window model built from offset/pre/post arithmetic.
module tb_trigger_window_reader;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        trigger;
  logic [31:0] trigger_offset;
  logic        wr_valid;
  logic [3:0]  pre_len;
  logic [3:0]  post_len;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;

  logic [15:0] mem [16];
  int          checks;
  int          errors;

  trigger_window_reader #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .OFFSET_DELAY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .trigger(trigger),
    .trigger_offset(trigger_offset),
    .wr_valid(wr_valid),
    .pre_len(pre_len),
    .post_len(post_len),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample buffer read port: data one cycle after the enable
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_watch(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (m_axis_tvalid || mem_rd_en || done) seen = 1'b1;
      tick();
    end
    check(tag, seen, 0);
  endtask

  task automatic acquire(input int pre, input int post, input logic [31:0] off,
                         input int mode, input string tag);
    int          len;
    int          need;
    int          a0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          exp_addr[$];
    int          got_addr[$];
    logic        prev_stall;
    logic [16:0] prev_beat;
    bit          got_done;
    int          cyc;

    len = pre + post + 1;
    if (len > 16) len = 16;
    need = len - pre - 1;
    a0   = int'(off[3:0]);
`ifdef READER_HEADER_EN
    exp_q.push_back({1'b0, off[15:0]});
`endif
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((a0 - pre + i + 16) % 16);
      exp_q.push_back({(i == len - 1), mem[(a0 - pre + i + 16) % 16]});
    end

    m_axis_tready  = 1'b0;
    pre_len        = 4'(pre);
    post_len       = 4'(post);
    trigger_offset = off;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    pre_len  = 4'($urandom);
    post_len = 4'($urandom);

    for (int w = 0; w < need; w++) begin
      if (w == need - 1) idle_watch(4, {tag, "_early"});
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      if (w < need - 1) repeat ($urandom_range(0, 2)) tick();
    end

    prev_stall = 1'b0;
    prev_beat  = '0;
    got_done   = 1'b0;
    for (cyc = 0; cyc < 300 && !got_done; cyc++) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (prev_stall)
        check({tag, "_stall_hold"}, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
      if (mem_rd_en) got_addr.push_back(int'(mem_rd_addr));
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
      if (done) got_done = 1'b1;
      tick();
    end
    m_axis_tready = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    @(negedge clk);
    check({tag, "_after_done"}, {done, busy, m_axis_tvalid}, 3'b000);
    tick();

    check({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_reads"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
  endtask

  initial begin
    bit seen_valid;
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    arm            = 1'b0;
    trigger        = 1'b0;
    trigger_offset = '0;
    wr_valid       = 1'b0;
    pre_len        = '0;
    post_len       = '0;
    m_axis_tready  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);

    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {busy, done, m_axis_tvalid, m_axis_tlast, mem_rd_en, m_axis_tdata},
          22'd0);
    tick();
    rst = 1'b0;
    tick();

    acquire(3, 4, 32'd10, 0, "basic");
    acquire(3, 2, 32'd1, 0, "wrap");
    acquire(10, 10, 32'd7, 0, "clamp");
    acquire(5, 6, 32'd3, 1, "stall");
    acquire(2, 0, 32'd9, 2, "post0");

    // Trigger edges in IDLE and a trigger already high at arm start nothing
    pre_len  = '0;
    post_len = '0;
    trigger  = 1'b1;
    tick();
    trigger  = 1'b0;
    idle_watch(3, "idle_trigger");
    @(negedge clk);
    check("idle_trigger_busy", busy, 0);
    tick();
    trigger = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    idle_watch(8, "held_trigger");
    @(negedge clk);
    check("held_trigger_armed", busy, 1);
    tick();
    trigger = 1'b0;
    tick();
    acquire(0, 0, 32'd5, 0, "after_held");

    // Reset while the window is being read out
    pre_len        = 4'd3;
    post_len       = 4'd4;
    trigger_offset = 32'd10;
    m_axis_tready  = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) begin
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 20 && !seen_valid; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) seen_valid = 1'b1;
      tick();
    end
    check("abort_reached_read", seen_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {m_axis_tvalid, busy, done, mem_rd_en}, 4'b0000);
    tick();
    acquire(3, 4, 32'd10, 0, "after_rst");

    for (int r = 0; r < 8; r++)
      acquire($urandom_range(0, 15), $urandom_range(0, 15), $urandom,
              $urandom_range(0, 2), $sformatf("rand%0d", r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_window_reader.md
Name: trigger_window_reader

Overview:
- Read-side counterpart of the level-trigger detector.
- Arms on request and waits for the detector's trigger pulse, then latches the trigger offset published by the detector.
- Waits until the requested number of post-trigger samples has been written into the circular sample buffer.
- Reads a pre/post-trigger window back out of the buffer's read port as an AXI-Stream packet for the DMA/HPS path.

Parameters:
- DATA_WIDTH, 16, sample width; matches buffer word width.
- ADDR_WIDTH, 10, buffer word-address width; depth = 2^ADDR_WIDTH.
- OFFSET_DELAY, 2, cycles after trigger rising edge at which trigger_offset is sampled (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arm  in  1  one-cycle request to start an acquisition; honoured only in IDLE.
- trigger  in  1  trigger from detector; rising edge used.
- trigger_offset  in  32  word address of trigger sample; low ADDR_WIDTH bits used.
- wr_valid  in  1  one pulse per sample written into the buffer.
- pre_len  in  ADDR_WIDTH  samples before the trigger sample (HPS register).
- post_len  in  ADDR_WIDTH  samples after the trigger sample (HPS register).
- mem_rd_en  out  1  buffer read enable.
- mem_rd_addr  out  ADDR_WIDTH  buffer read address.
- mem_rd_data  in  DATA_WIDTH  read data; valid exactly 1 cycle after mem_rd_en.
- m_axis_tdata  out  DATA_WIDTH  window sample.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  final beat of window.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO and counters cleared; in-flight read discarded. Reset mid-packet truncates the packet with no tlast.

- States:
  - IDLE: arm -> ARMED.
  - ARMED: trigger rising edge (trigger=1, previous=0) -> TRIG_WAIT. A trigger already high when ARMED is entered is not an edge.
  - TRIG_WAIT: counts OFFSET_DELAY cycles. On the last one, latches start = trigger_offset[ADDR_WIDTH-1:0] - pre_len (mod 2^ADDR_WIDTH) -> POST.
  - POST: waits until the post-trigger counter >= post_len -> READ. With post_len=0 it leaves after one cycle.
  - READ: issues reads; after the final beat handshake -> DONE.
  - DONE: done=1 for one cycle -> IDLE.

- Post-trigger counting:
  - Counter clears on the trigger edge and counts wr_valid pulses from the cycle after the edge, including cycles spent in TRIG_WAIT.
  - Counter saturates at post_len.

- Window length:
  - len = pre_len + post_len + 1, computed ADDR_WIDTH+1 bits wide.
  - If len > 2^ADDR_WIDTH, post_len is clamped so that len = 2^ADDR_WIDTH.
  - pre_len and post_len are sampled on the trigger edge; later register changes do not affect the window.

- Read engine:
  - Address starts at start and increments by 1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - Exactly len reads are issued.
  - Output is a 2-entry FIFO. A read is issued when occupancy + inflight - (tvalid & tready) < 2, which sustains 1 beat/cycle under continuous tready.
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
  - tlast is high on beat len only.
- Latency: first tvalid 2 cycles after entering READ.
- arm outside IDLE is ignored. A trigger edge outside ARMED is ignored.

Optional Feature:
- Macro READER_HEADER_EN.
- When defined:
  - One header beat precedes the samples. Its tdata = trigger_offset latched value zero-extended or truncated to DATA_WIDTH.
  - The header beat is presented at READ entry with no memory read. The packet is len+1 beats; tlast stays on the final sample.
- When undefined: no header beat; the packet is exactly len beats.

Test Plan:
- ADDR_WIDTH=4, pre_len=3, post_len=4, trigger_offset=10, tready=1, after arm + trigger + 4 wr_valid -> reads addr 7..14, 8 beats, tlast on beat 8, done pulse.
- trigger_offset=1, pre_len=3, post_len=2 -> addresses 14,15,0,1,2,3 (wrap), 6 beats.
- pre_len=10, post_len=10, ADDR_WIDTH=4 -> post clamped to 5, 16 beats.
- tready toggled 1,0,0,1 pattern during READ -> data sequence unchanged, no beat lost or duplicated, tdata stable while stalled.
- trigger pulses in IDLE and while trigger held high at arm -> no acquisition until a new rising edge.
- rst asserted mid-READ -> tvalid=0, busy=0 next cycle; new arm produces a clean full packet. With READER_HEADER_EN: first beat = 10.
